// File: rtl/oled_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers exposed on reg_out,
// plus a one-cycle write strobe per register.
module oled_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic [2:0]                          S_AXI_AWPROT,
   input  logic                                S_AXI_AWVALID,
   output logic                                S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
   input  logic                                S_AXI_WVALID,
   output logic                                S_AXI_WREADY,
   output logic [1:0]                          S_AXI_BRESP,
   output logic                                S_AXI_BVALID,
   input  logic                                S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic [2:0]                          S_AXI_ARPROT,
   input  logic                                S_AXI_ARVALID,
   output logic                                S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
   output logic [1:0]                          S_AXI_RRESP,
   output logic                                S_AXI_RVALID,
   input  logic                                S_AXI_RREADY,
   output logic [3:0][C_S_AXI_DATA_WIDTH-1:0]  reg_out,
   output logic [3:0]                          reg_wr_stb
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb_v);
      logic [DW-1:0] res_v;
      res_v = old_v;
      for (int k = 0; k < SW; k++) begin
         if (strb_v[k]) res_v[8*k +: 8] = new_v[8*k +: 8];
         else           res_v[8*k +: 8] = old_v[8*k +: 8];
      end
      return res_v;
   endfunction

   w_state_t              w_state_r, w_next_s;
   r_state_t              r_state_r, r_next_s;
   logic                  wr_hs_s, rd_hs_s;
   logic [1:0]            wr_idx_s, rd_idx_s;
   logic                  wr_oor_s, rd_oor_s;
   logic [3:0][DW-1:0]    regs_r;
   logic [3:0]            wr_stb_r;
   logic                  bvalid_r, rvalid_r;
   logic [1:0]            bresp_r, rresp_r;
   logic [DW-1:0]         rdata_r;
   logic                  unused_s;

   // Any address bit at or above bit 4 selects nothing.
   assign wr_idx_s = S_AXI_AWADDR[3:2];
   assign rd_idx_s = S_AXI_ARADDR[3:2];
   assign wr_oor_s = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign rd_oor_s = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Write FSM next state: AW and W are accepted together or not at all
   always_comb begin
      w_next_s = w_state_r;
      wr_hs_s  = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               wr_hs_s  = 1'b1;
               w_next_s = W_RESP;
            end else begin
               w_next_s = W_IDLE;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) w_next_s = W_IDLE;
            else              w_next_s = W_RESP;
         end
         default: w_next_s = W_IDLE;
      endcase
   end

   // Read FSM next state
   always_comb begin
      r_next_s = r_state_r;
      rd_hs_s  = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            if (S_AXI_ARVALID) begin
               rd_hs_s  = 1'b1;
               r_next_s = R_DATA;
            end else begin
               r_next_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) r_next_s = R_IDLE;
            else              r_next_s = R_DATA;
         end
         default: r_next_s = R_IDLE;
      endcase
   end

   // FSM state registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_r <= W_IDLE;
         r_state_r <= R_IDLE;
      end else begin
         w_state_r <= w_next_s;
         r_state_r <= r_next_s;
      end
   end

   // Register file, write strobes and write response
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         regs_r   <= {(4*DW){1'b0}};
         wr_stb_r <= 4'b0000;
         bvalid_r <= 1'b0;
         bresp_r  <= 2'b00;
      end else begin
         wr_stb_r <= 4'b0000;
         if (wr_hs_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_oor_s ? 2'b10 : 2'b00;
            if (!wr_oor_s) begin
               regs_r[wr_idx_s]   <= strb_merge(regs_r[wr_idx_s], S_AXI_WDATA, S_AXI_WSTRB);
               wr_stb_r[wr_idx_s] <= 1'b1;
            end
         end else if (bvalid_r && S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Read response; sampling regs_r here returns the pre-write value on a collision
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rvalid_r <= 1'b0;
         rresp_r  <= 2'b00;
         rdata_r  <= {DW{1'b0}};
      end else begin
         if (rd_hs_s) begin
            rvalid_r <= 1'b1;
            if (rd_oor_s) begin
               rresp_r <= 2'b10;
               rdata_r <= {DW{1'b0}};
            end else begin
               rresp_r <= 2'b00;
               rdata_r <= regs_r[rd_idx_s];
            end
         end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = wr_hs_s & ~ARESET;
   assign S_AXI_WREADY  = wr_hs_s & ~ARESET;
   assign S_AXI_ARREADY = (r_state_r == R_IDLE) & ~ARESET;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_BRESP   = bresp_r;
   assign S_AXI_RVALID  = rvalid_r;
   assign S_AXI_RRESP   = rresp_r;
   assign S_AXI_RDATA   = rdata_r;
   assign reg_out       = regs_r;
   assign reg_wr_stb    = wr_stb_r;

endmodule

// File: tb/tb_oled_axil_regs.sv
// Bench for oled_axil_regs: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_oled_axil_regs;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [3:0][31:0] reg_out;
   logic [3:0]  wr_stb;

   oled_axil_regs dut (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out), .reg_wr_stb(wr_stb)
   );

   logic [31:0] mdl [4];
   int exp_stb [4];
   int seen_stb [4];
   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // count strobe cycles, sampled away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) seen_stb[i] += int'(wr_stb[i]);
   end

   function automatic void model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      if (addr < 5'd16) begin
         idx = int'(addr) / 4;
         for (int k = 0; k < 4; k++)
            if (strb[k]) mdl[idx][8*k +: 8] = data[8*k +: 8];
         exp_stb[idx]++;
      end
   endfunction

   function automatic logic [1:0] exp_resp(input logic [4:0] addr);
      return (addr >= 5'd16) ? 2'b10 : 2'b00;
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("%s_reg%0d", tag, i), reg_out[i], mdl[i]);
         check_val($sformatf("%s_stb%0d", tag, i), 32'(seen_stb[i]), 32'(exp_stb[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_awready"}, 32'(awready), 32'd0);
      check_val({tag, "_wready"},  32'(wready),  32'd0);
      check_val({tag, "_arready"}, 32'(arready), 32'd0);
      check_val({tag, "_bvalid"},  32'(bvalid),  32'd0);
      check_val({tag, "_rvalid"},  32'(rvalid),  32'd0);
      check_val({tag, "_bresp"},   32'(bresp),   32'd0);
      check_val({tag, "_rresp"},   32'(rresp),   32'd0);
      check_val({tag, "_rdata"},   rdata,        32'd0);
      check_val({tag, "_stb"},     32'(wr_stb),  32'd0);
      for (int i = 0; i < 4; i++) check_val($sformatf("%s_reg%0d", tag, i), reg_out[i], 32'd0);
   endtask

   // lead > 0: AW first by lead cycles; lead < 0: W first
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdly, input bit do_rst, output logic [1:0] resp);
      int cyc;
      bit hs, done;
      cyc = 0; done = 1'b0;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom_range(0, 7));
      while (!done && cyc < 20) begin
         awvalid = (lead < 0) ? (cyc >= -lead) : 1'b1;
         wvalid  = (lead > 0) ? (cyc >= lead)  : 1'b1;
         #1;
         hs = awready && wready;
         if (!(awvalid && wvalid)) begin
            check_val("wait_awready", 32'(awready), 32'd0);
            check_val("wait_wready",  32'(wready),  32'd0);
         end
         @(negedge clk);
         cyc++;
         if (hs) done = 1'b1;
      end
      check_val("w_handshake", 32'(done), 32'd1);
      #1;
      check_val("wresp_awready", 32'(awready), 32'd0);
      check_val("bvalid_lat", 32'(bvalid), 32'd1);
      resp = bresp;
      if (do_rst) begin
         awvalid = 1'b0; wvalid = 1'b0;
         #1;
         rst = 1'b1;
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         #1;
         check_reset_outputs("mid_rst");
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         for (int i = 0; i < bdly; i++) begin
            check_val("bvalid_hold", 32'(bvalid), 32'd1);
            check_val("bresp_hold", 32'(bresp), 32'(resp));
            check_val("wresp_wready", 32'(wready), 32'd0);
            @(negedge clk);
         end
         awvalid = 1'b0; wvalid = 1'b0;
         bready = 1'b1;
         @(negedge clk);
         bready = 1'b0;
         check_val("bvalid_clr", 32'(bvalid), 32'd0);
      end
   endtask

   task automatic axi_read(input logic [4:0] addr, input int rdly, output logic [31:0] data, output logic [1:0] resp);
      int cyc;
      bit done;
      cyc = 0; done = 1'b0;
      @(negedge clk);
      araddr = addr; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1;
      while (!done && cyc < 20) begin
         #1;
         if (arready) done = 1'b1;
         @(negedge clk);
         cyc++;
      end
      arvalid = 1'b0;
      check_val("ar_handshake", 32'(done), 32'd1);
      check_val("rvalid_lat", 32'(rvalid), 32'd1);
      data = rdata; resp = rresp;
      for (int i = 0; i < rdly; i++) begin
         check_val("rvalid_hold", 32'(rvalid), 32'd1);
         check_val("rdata_hold", rdata, data);
         check_val("rresp_hold", 32'(rresp), 32'(resp));
         check_val("rdata_arready", 32'(arready), 32'd0);
         @(negedge clk);
      end
      rready = 1'b1;
      #1;
      check_val("rhs_arready", 32'(arready), 32'd0);
      @(negedge clk);
      rready = 1'b0;
      #1;
      check_val("rvalid_clr", 32'(rvalid), 32'd0);
      check_val("ridle_arready", 32'(arready), 32'd1);
   endtask

   logic [1:0]  resp, rresp_o;
   logic [31:0] rd_o, exp_old;
   logic [4:0]  a;
   logic [31:0] d;
   logic [3:0]  s;

   initial begin
      rst = 1'b1;
      awaddr = 5'd0; araddr = 5'd0; awprot = 3'd0; arprot = 3'd0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'd0; wstrb = 4'd0;
      for (int i = 0; i < 4; i++) begin mdl[i] = 32'd0; exp_stb[i] = 0; seen_stb[i] = 0; end
      #3;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;

      // basic writes and readbacks
      for (int i = 0; i < 4; i++) begin
         a = 5'(4 * i);
         axi_write(a, 32'(i + 1), 4'hF, 0, 0, 1'b0, resp);
         model_write(a, 32'(i + 1), 4'hF);
         check_val("basic_bresp", 32'(resp), 32'd0);
      end
      check_regs("basic");
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(4 * i), 0, rd_o, rresp_o);
         check_val("basic_rdata", rd_o, 32'(i + 1));
         check_val("basic_rresp", 32'(rresp_o), 32'd0);
      end

      // byte strobes over a cleared register
      axi_write(5'h04, 32'd0, 4'hF, 0, 0, 1'b0, resp);
      model_write(5'h04, 32'd0, 4'hF);
      axi_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 1'b0, resp);
      model_write(5'h04, 32'hAABBCCDD, 4'b0101);
      axi_read(5'h04, 0, rd_o, rresp_o);
      check_val("strb_rdata", rd_o, 32'h00BB00DD);

      // AW leads W by 3, BREADY held off 5 cycles
      axi_write(5'h08, 32'h12345678, 4'hF, 3, 5, 1'b0, resp);
      model_write(5'h08, 32'h12345678, 4'hF);
      check_val("lead_bresp", 32'(resp), 32'd0);
      check_regs("lead");

      // W leads AW, zero strobe
      axi_write(5'h0C, 32'hFFFFFFFF, 4'b0000, -2, 1, 1'b0, resp);
      model_write(5'h0C, 32'hFFFFFFFF, 4'b0000);
      check_val("zstrb_bresp", 32'(resp), 32'd0);
      check_regs("zstrb");

      // out of range
      axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, resp);
      model_write(5'h10, 32'hDEADBEEF, 4'hF);
      check_val("oor_bresp", 32'(resp), 32'd2);
      check_regs("oor");
      axi_read(5'h10, 0, rd_o, rresp_o);
      check_val("oor_rdata", rd_o, 32'd0);
      check_val("oor_rresp", 32'(rresp_o), 32'd2);

      // RREADY held off 4 cycles
      axi_read(5'h08, 4, rd_o, rresp_o);
      check_val("rhold_rdata", rd_o, mdl[2]);

      // same-register collision returns the pre-write value
      exp_old = mdl[0];
      fork
         axi_write(5'h00, 32'hCAFEF00D, 4'hF, 0, 0, 1'b0, resp);
         axi_read(5'h00, 0, rd_o, rresp_o);
      join
      model_write(5'h00, 32'hCAFEF00D, 4'hF);
      check_val("coll_rdata", rd_o, exp_old);
      check_regs("coll");

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         a = 5'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) a[4] = 1'b1;
         if ($urandom_range(0, 2) != 0) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3), 1'b0, resp);
            model_write(a, d, s);
            check_val("rnd_bresp", 32'(resp), 32'(exp_resp(a)));
            check_regs("rnd");
         end else begin
            axi_read(a, $urandom_range(0, 3), rd_o, rresp_o);
            check_val("rnd_rdata", rd_o, (a >= 5'd16) ? 32'd0 : mdl[a[3:2]]);
            check_val("rnd_rresp", 32'(rresp_o), 32'(exp_resp(a)));
         end
      end

      // reset while BVALID pending
      axi_write(5'h04, 32'h55AA55AA, 4'hF, 0, 0, 1'b1, resp);
      model_write(5'h04, 32'h55AA55AA, 4'hF);
      for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
      check_regs("post_rst");
      axi_write(5'h0C, 32'h0BADF00D, 4'hF, 0, 0, 1'b0, resp);
      model_write(5'h0C, 32'h0BADF00D, 4'hF);
      check_val("post_rst_bresp", 32'(resp), 32'd0);
      check_regs("post_rst_wr");
      axi_read(5'h0C, 0, rd_o, rresp_o);
      check_val("post_rst_rdata", rd_o, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/oled_axil_regs.md
OLED_AXIL_REGS -- requirements
Module: oled_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the AXI4-Lite data width (only 32 is supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, meaning the byte-address width.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have the AW channel: S_AXI_AWADDR in [ADDR_W], S_AXI_AWPROT in [3], S_AXI_AWVALID in [1], S_AXI_AWREADY out [1].
REQ-006 SHALL have the W channel: S_AXI_WDATA in [32], S_AXI_WSTRB in [4], S_AXI_WVALID in [1], S_AXI_WREADY out [1].
REQ-007 SHALL have the B channel: S_AXI_BRESP out [2], S_AXI_BVALID out [1], S_AXI_BREADY in [1].
REQ-008 SHALL have the AR channel: S_AXI_ARADDR in [ADDR_W], S_AXI_ARPROT in [3], S_AXI_ARVALID in [1], S_AXI_ARREADY out [1].
REQ-009 SHALL have the R channel: S_AXI_RDATA out [32], S_AXI_RRESP out [2], S_AXI_RVALID out [1], S_AXI_RREADY in [1].
REQ-010 SHALL have port reg_out, output, 4x32 bits: the current contents of registers 0..3.
REQ-011 SHALL have port reg_wr_stb, output, 4 bits: a one-cycle pulse per register on each accepted write to that register.

Function
REQ-012 SHALL decode four 32-bit read/write registers at byte offsets 0x00, 0x04, 0x08 and 0x0C; register index = ADDR[3:2]; ADDR[1:0] is ignored.
REQ-013 SHALL treat an address with any bit at or above bit 4 as out of range: SLVERR (2'b10), no register update, RDATA = 0.
REQ-014 Write FSM SHALL have states W_IDLE, W_RESP.
- W_IDLE: AWREADY and WREADY are both asserted only in the same cycle in which AWVALID and WVALID are both high.
- Either channel's VALID may arrive first; the block SHALL wait for the other without asserting its READY.
REQ-015 On the AW/W handshake cycle, the block SHALL update the addressed register bytewise under WSTRB (byte k updated iff WSTRB[k]).
REQ-016 On that same cycle it SHALL pulse reg_wr_stb[idx], go to W_RESP, assert BVALID with BRESP OKAY (2'b00) or SLVERR, and not pulse reg_wr_stb if out of range.
REQ-017 reg_out SHALL reflect new data the cycle after the handshake; write latency from handshake to BVALID is 1 cycle.
REQ-018 In W_RESP the block SHALL hold BVALID/BRESP stable until BREADY, then return to W_IDLE; AWREADY/WREADY SHALL stay low throughout W_RESP.
REQ-019 Read FSM SHALL have states R_IDLE, R_DATA.
- R_IDLE: ARREADY = 1.
- On ARVALID the block SHALL capture the address, go to R_DATA, and assert RVALID the next cycle with RDATA and RRESP.
REQ-020 In R_DATA the block SHALL hold RVALID/RDATA/RRESP stable until RREADY, then return to R_IDLE; ARREADY = 0 throughout R_DATA.
REQ-021 Read and write FSMs SHALL run independently.
- On a same-register collision in one cycle, the read SHALL return the pre-write value.
REQ-022 WSTRB = 4'b0000 SHALL complete with OKAY, no data change, and reg_wr_stb still pulsed.
REQ-023 AWPROT/ARPROT SHALL be ignored.

Reset
REQ-024 While ARESET = 1, asynchronously, the block SHALL:
- force all READY/VALID outputs to 0, BRESP/RRESP/RDATA to 0, reg_out to 0 and reg_wr_stb to 0;
- put both FSMs into their IDLE states.
REQ-025 A reset mid-transaction (e.g. BVALID pending) SHALL drop the response; no write is committed unless its handshake completed before reset.
REQ-026 After ARESET deasserts, the block SHALL accept transactions from the first rising edge.

Verification
REQ-027 The bench SHALL cover: writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC -> each BRESP OKAY; readbacks return 0x1..0x4 with RRESP OKAY.
REQ-028 The bench SHALL cover: write 0xAABBCCDD to 0x4 with WSTRB 0b0101 over a prior value of 0 -> read 0x4 returns 0x00BB00DD.
REQ-029 The bench SHALL cover: AWVALID 3 cycles before WVALID, with BREADY held low 5 cycles -> a single handshake, BVALID held stable 5 cycles, reg_wr_stb[idx] pulsed exactly once.
REQ-030 The bench SHALL cover: write/read to 0x10 -> BRESP SLVERR, RRESP SLVERR, RDATA 0, all reg_out unchanged.
REQ-031 The bench SHALL cover: RREADY held low 4 cycles after an AR to 0x8 -> RVALID/RDATA stable; ARREADY low until the R handshake.
REQ-032 The bench SHALL cover: ARESET pulsed while BVALID = 1 -> BVALID = 0 immediately; reg_out all 0; the next write completes normally.
